taps_lfsr: RTL and testbench
============================

TAPS_LFSR -- requirements
Module: taps_lfsr

Interface
REQ-001 Parameter NUM_OF_TAPS, default 8: number of 8-bit tap fields in taps.
REQ-002 Parameter SIZE, default 32: shift-register length in bits.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 res  input  1  reset; asynchronous, active-low.
REQ-005 taps  input  NUM_OF_TAPS*8  tap positions, field k = taps[k*8+7:k*8], value = register position 1..SIZE-1.
REQ-006 taps_done  input  1  taps valid and stable, held high by the upstream selector.
REQ-007 seed  input  SIZE  initial register value.
REQ-008 ena  input  1  global advance enable.
REQ-009 restart  input  1  sync return to IDLE (re-capture taps).
REQ-010 out_ready  input  1  consumer accepts dout this cycle.
REQ-011 dout  output  8  generated byte.
REQ-012 dout_valid  output  1  dout holds a valid byte.
REQ-013 busy  output  1  high in LOAD/RUN.

Function
REQ-014 FSM states: IDLE, LOAD, RUN; all transitions require ena=1, except restart.
REQ-015 IDLE -> LOAD when taps_done=1; in LOAD, feedback mask SHALL be registered and state <= seed, or SIZE'h1 when seed==0.
REQ-016 Mask rule: bit (t-1) set for each field t in 1..SIZE-1; t==0 or t>=SIZE ignored; duplicates OR'd (no cancellation); bit SIZE-1 always set.
REQ-017 LOAD -> RUN unconditionally after one cycle.
REQ-018 RUN, ena=1, not stalled: fb = XOR-reduce(state & mask); state <= {state[SIZE-2:0], fb}; bit counter 0..7 increments.
REQ-019 On the 8th shift (counter wraps 7->0): dout <= low 8 bits of the new state (first generated bit in dout[7]), dout_valid <= 1.
REQ-020 Stall: dout_valid=1 && out_ready=0 freezes state, counter, dout.
REQ-021 Handshake: dout_valid && out_ready in a cycle clears dout_valid next cycle unless a new byte completes that same cycle, in which case dout_valid stays 1 with the new byte (throughput 1 byte / 8 cycles).
REQ-022 ena=0: all registers hold, including dout_valid.
REQ-023 taps/seed changes after LOAD SHALL be ignored until restart or reset.
REQ-024 restart=1 (any state, regardless of ena): next cycle IDLE, dout_valid=0, counter=0; mask retained but recaptured on next LOAD.
REQ-025 busy SHALL equal (state != IDLE), combinational from the state register.

Reset
REQ-026 res=0 asynchronously forces: IDLE, state register 0, mask 0, counter 0, dout 8'h00, dout_valid 0, busy 0.
REQ-027 Reset deassertion SHALL be synchronised externally; first active edge after release evaluates IDLE.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, default NUM_OF_TAPS/SIZE, and BYTE_BITS=8.
REQ-029 One sub-module tap_mask_decode (combinational taps -> SIZE-bit mask) SHALL be used; remainder in taps_lfsr.

Verification
REQ-030 taps fields {1,2, rest 0}, seed 32'h1, ena=1, out_ready=1 -> mask 32'h8000_0003, first dout=8'hB6 valid 10 cycles after taps_done rises.
REQ-031 Same taps, seed 32'h0 -> identical first byte 8'hB6 (seed substituted with 1).
REQ-032 out_ready=0 for 20 cycles after first byte -> dout stays 8'hB6, dout_valid stays 1, next byte appears 8 cycles after out_ready rises.
REQ-033 Tap fields {40, 0, 1, 1} -> mask 32'h8000_0001 (40 and 0 ignored, duplicate 1 not cancelled).
REQ-034 res pulsed low mid-RUN between clock edges -> outputs zero immediately, FSM IDLE; restart mid-RUN -> IDLE next edge, dout_valid=0.
REQ-035 ena=0 for 5 cycles mid-byte -> byte completion delayed exactly 5 cycles, value unchanged.

Source files
------------

// File: rtl/taps_lfsr_pkg.sv
// ============================================================================
// taps_lfsr_pkg : shared FSM encoding and default sizes for taps_lfsr
// Rev 1.0
// ============================================================================
`default_nettype none

package taps_lfsr_pkg;

  localparam int DEF_NUM_OF_TAPS = 8;
  localparam int DEF_SIZE        = 32;
  localparam int BYTE_BITS       = 8;

  localparam int FSM_W = 2;
  localparam logic [FSM_W-1:0] ST_IDLE = 2'd0;
  localparam logic [FSM_W-1:0] ST_LOAD = 2'd1;
  localparam logic [FSM_W-1:0] ST_RUN  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/tap_mask_decode.sv
// ============================================================================
// tap_mask_decode : combinational tap-position list -> LFSR feedback mask
// Rev 1.0
// ============================================================================
`default_nettype none

module tap_mask_decode
  import taps_lfsr_pkg::*;
#(
  parameter int NUM_OF_TAPS = DEF_NUM_OF_TAPS,
  parameter int SIZE        = DEF_SIZE
) (
  input  logic [NUM_OF_TAPS*BYTE_BITS-1:0] i_taps,
  output logic [SIZE-1:0]                  o_mask
);

  // Out-of-range positions (0, >= SIZE) never match; duplicates just re-set the bit.
  always_comb begin
    o_mask         = '0;
    o_mask[SIZE-1] = 1'b1;
    for (int pos = 1; pos < SIZE; pos++) begin
      for (int k = 0; k < NUM_OF_TAPS; k++) begin
        if (int'(i_taps[k*BYTE_BITS +: BYTE_BITS]) == pos) begin
          o_mask[pos-1] = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/taps_lfsr.sv
// ============================================================================
// taps_lfsr : Fibonacci LFSR byte generator with runtime tap list and handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module taps_lfsr
  import taps_lfsr_pkg::*;
#(
  parameter int NUM_OF_TAPS = DEF_NUM_OF_TAPS,
  parameter int SIZE        = DEF_SIZE
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic [NUM_OF_TAPS*BYTE_BITS-1:0] taps,
  input  logic                             taps_done,
  input  logic [SIZE-1:0]                  seed,
  input  logic                             ena,
  input  logic                             restart,
  input  logic                             out_ready,
  output logic [BYTE_BITS-1:0]             dout,
  output logic                             dout_valid,
  output logic                             busy
);

  localparam int                CNT_W      = $clog2(BYTE_BITS);
  localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(BYTE_BITS - 1);
  localparam logic [SIZE-1:0]   c_SEED_ONE = SIZE'(1);

  logic [FSM_W-1:0]     r_fsm;
  logic [FSM_W-1:0]     w_fsm_next;
  logic [SIZE-1:0]      r_lfsr;
  logic [SIZE-1:0]      r_mask;
  logic [SIZE-1:0]      w_mask;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [BYTE_BITS-1:0] r_dout;
  logic                 r_dout_valid;
  logic                 w_fb;
  logic [SIZE-1:0]      w_lfsr_next;
  logic                 w_stall;
  logic                 w_advance;
  logic                 w_byte_done;

  tap_mask_decode #(
    .NUM_OF_TAPS (NUM_OF_TAPS),
    .SIZE        (SIZE)
  ) u_tap_mask_decode (
    .i_taps (taps),
    .o_mask (w_mask)
  );

  assign w_fb        = ^(r_lfsr & r_mask);
  assign w_lfsr_next = {r_lfsr[SIZE-2:0], w_fb};
  assign w_stall     = r_dout_valid && !out_ready;
  assign w_advance   = ena && !restart && (r_fsm == ST_RUN) && !w_stall;
  assign w_byte_done = w_advance && (r_bit_cnt == c_CNT_LAST);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // restart overrides ena; every other transition waits for ena.
  always_comb begin
    w_fsm_next = r_fsm;
    if (restart) begin
      w_fsm_next = ST_IDLE;
    end else if (ena) begin
      case (r_fsm)
        ST_IDLE: if (taps_done) w_fsm_next = ST_LOAD;
        ST_LOAD: w_fsm_next = ST_RUN;
        ST_RUN:  w_fsm_next = ST_RUN;
        default: w_fsm_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_fsm != ST_IDLE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_lfsr       <= '0;
      r_mask       <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (restart) begin
      r_bit_cnt    <= '0;
      r_dout_valid <= 1'b0;
    end else if (ena) begin
      if (r_fsm == ST_LOAD) begin
        r_mask <= w_mask;
        r_lfsr <= (seed == '0) ? c_SEED_ONE : seed;
      end
      if (w_advance) begin
        r_lfsr    <= w_lfsr_next;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      // A byte completing in the same cycle as a handshake keeps valid high.
      if (w_byte_done) begin
        r_dout       <= w_lfsr_next[BYTE_BITS-1:0];
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && out_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

`default_nettype wire

// File: tb/tb_taps_lfsr.sv
// ============================================================================
// tb_taps_lfsr : randomized self-checking bench for taps_lfsr
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_taps_lfsr;

  localparam int NT = 8;
  localparam int SZ = 32;

  logic            clk = 1'b0;
  logic            res;
  logic [NT*8-1:0] taps;
  logic            taps_done;
  logic [SZ-1:0]   seed;
  logic            ena;
  logic            restart;
  logic            out_ready;
  logic [7:0]      dout;
  logic            dout_valid;
  logic            busy;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  taps_lfsr #(.NUM_OF_TAPS(NT), .SIZE(SZ)) dut (
    .clk        (clk),
    .res        (res),
    .taps       (taps),
    .taps_done  (taps_done),
    .seed       (seed),
    .ena        (ena),
    .restart    (restart),
    .out_ready  (out_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  function automatic logic [NT*8-1:0] mk_taps(input int f0, input int f1, input int f2, input int f3);
    logic [NT*8-1:0] t;
    t        = '0;
    t[7:0]   = 8'(f0);
    t[15:8]  = 8'(f1);
    t[23:16] = 8'(f2);
    t[31:24] = 8'(f3);
    return t;
  endfunction

  function automatic logic [NT*8-1:0] rand_taps();
    logic [NT*8-1:0] t;
    for (int k = 0; k < NT; k++) t[k*8 +: 8] = 8'($urandom_range(0, 40));
    return t;
  endfunction

  function automatic logic [SZ-1:0] model_mask(input logic [NT*8-1:0] t);
    logic [SZ-1:0] m;
    int v;
    m = '0;
    m[SZ-1] = 1'b1;
    for (int k = 0; k < NT; k++) begin
      v = int'(t[k*8 +: 8]);
      if (v >= 1 && v < SZ) m[v-1] = 1'b1;
    end
    return m;
  endfunction

  // Expected byte stream: each new bit is the parity of the tapped bits, appended at the LSB.
  task automatic model_run(input logic [NT*8-1:0] t, input logic [SZ-1:0] s0, input int nbytes);
    logic [SZ-1:0] m;
    logic [SZ-1:0] s;
    logic          fb;
    m = model_mask(t);
    s = (s0 == '0) ? SZ'(1) : s0;
    exp_q.delete();
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 0; i < 8; i++) begin
        fb   = ($countones(s & m) % 2) == 1;
        s    = s << 1;
        s[0] = fb;
      end
      exp_q.push_back(s[7:0]);
    end
  endtask

  task automatic do_reset();
    res = 1'b0; taps_done = 1'b0; ena = 1'b0; restart = 1'b0;
    out_ready = 1'b0; taps = '0; seed = '0;
    repeat (2) @(negedge clk);
    res = 1'b1;
  endtask

  task automatic start(input logic [NT*8-1:0] t, input logic [SZ-1:0] s);
    @(negedge clk);
    taps = t; seed = s; taps_done = 1'b1; ena = 1'b1;
  endtask

  task automatic wait_valid(input int maxc, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end while (!dout_valid && cyc < maxc);
  endtask

  task automatic test_reset();
    res = 1'b0; taps_done = 1'b0; ena = 1'b1; restart = 1'b0;
    out_ready = 1'b0; taps = '0; seed = '0;
    #1;
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    vectors++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (dut.r_mask !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h expected 0", dut.r_mask); end
    @(negedge clk); res = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int cyc;
    logic [NT*8-1:0] t;
    do_reset();
    t = mk_taps(1, 2, 0, 0);
    model_run(t, 32'h1, 4);
    out_ready = 1'b1;
    start(t, 32'h1);
    wait_valid(40, cyc);
    vectors++; if (cyc !== 10 || dout_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %0d expected 10", cyc); end
    vectors++; if (dout !== 8'hB6) begin errors++; $display("FAIL basic_first_byte: got %h expected b6", dout); end
    vectors++; if (dut.r_mask !== 32'h8000_0003) begin errors++; $display("FAIL basic_mask: got %h expected 80000003", dut.r_mask); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    for (int b = 1; b < 4; b++) begin
      wait_valid(20, cyc);
      vectors++; if (cyc !== 8 || dout !== exp_q[b]) begin
        errors++; $display("FAIL back_to_back_byte%0d: got %h after %0d cycles expected %h after 8", b, dout, cyc, exp_q[b]);
      end
    end
  endtask

  task automatic test_seed_zero();
    int cyc;
    do_reset();
    out_ready = 1'b1;
    start(mk_taps(1, 2, 0, 0), 32'h0);
    wait_valid(40, cyc);
    vectors++; if (cyc !== 10 || dout !== 8'hB6) begin
      errors++; $display("FAIL seed_zero: got %h after %0d cycles expected b6 after 10", dout, cyc);
    end
  endtask

  task automatic test_stall();
    int cyc;
    int bad;
    logic [NT*8-1:0] t;
    do_reset();
    t = mk_taps(1, 2, 0, 0);
    model_run(t, 32'h1, 2);
    start(t, 32'h1);
    wait_valid(40, cyc);
    bad = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (dout !== 8'hB6 || dout_valid !== 1'b1) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d disturbed cycles expected 0", bad); end
    out_ready = 1'b1;
    wait_valid(20, cyc);
    vectors++; if (cyc !== 8 || dout !== exp_q[1]) begin
      errors++; $display("FAIL stall_resume: got %h after %0d cycles expected %h after 8", dout, cyc, exp_q[1]);
    end
  endtask

  task automatic test_mask_rule();
    int cyc;
    logic [NT*8-1:0] t;
    logic [SZ-1:0]   s;
    do_reset();
    t = mk_taps(40, 0, 1, 1);
    s = SZ'($urandom) | SZ'(1);
    model_run(t, s, 1);
    out_ready = 1'b1;
    start(t, s);
    wait_valid(40, cyc);
    vectors++; if (dut.r_mask !== 32'h8000_0001) begin errors++; $display("FAIL mask_rule: got %h expected 80000001", dut.r_mask); end
    vectors++; if (cyc !== 10 || dout !== exp_q[0]) begin
      errors++; $display("FAIL mask_rule_byte: got %h after %0d cycles expected %h after 10", dout, cyc, exp_q[0]);
    end
  endtask

  task automatic test_ena_gap();
    int cyc;
    bit got;
    do_reset();
    out_ready = 1'b1;
    start(mk_taps(1, 2, 0, 0), 32'h1);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (dout_valid) got = 1'b1;
      if (cyc == 5)  ena = 1'b0;
      if (cyc == 10) ena = 1'b1;
    end
    vectors++; if (cyc !== 15 || dout !== 8'hB6) begin
      errors++; $display("FAIL ena_gap: got %h after %0d cycles expected b6 after 15", dout, cyc);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    do_reset();
    start(mk_taps(1, 2, 0, 0), 32'h1);
    wait_valid(40, cyc);
    #2 res = 1'b0;
    #1;
    vectors++; if (dout !== 8'h00 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got dout=%h valid=%b busy=%b expected 00/0/0", dout, dout_valid, busy);
    end
    taps_done = 1'b0;
    #1 res = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_idle: got %b expected 0", busy); end
  endtask

  task automatic test_restart();
    int cyc;
    logic [NT*8-1:0] t2;
    logic [SZ-1:0]   s2;
    do_reset();
    start(mk_taps(1, 2, 0, 0), 32'h1);
    wait_valid(40, cyc);
    restart = 1'b1; ena = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL restart: got busy=%b valid=%b expected 0/0", busy, dout_valid);
    end
    t2 = rand_taps();
    s2 = SZ'($urandom);
    model_run(t2, s2, 1);
    restart = 1'b0; ena = 1'b1; out_ready = 1'b1;
    taps = t2; seed = s2;
    wait_valid(40, cyc);
    vectors++; if (dut.r_mask !== model_mask(t2)) begin errors++; $display("FAIL restart_mask: got %h expected %h", dut.r_mask, model_mask(t2)); end
    vectors++; if (cyc !== 10 || dout !== exp_q[0]) begin
      errors++; $display("FAIL restart_byte: got %h after %0d cycles expected %h after 10", dout, cyc, exp_q[0]);
    end
  endtask

  task automatic test_random();
    int cyc;
    int n;
    logic [NT*8-1:0] t;
    logic [SZ-1:0]   s;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      t = rand_taps();
      s = ($urandom_range(0, 3) == 0) ? '0 : SZ'($urandom);
      model_run(t, s, 6);
      out_ready = 1'b1;
      start(t, s);
      n = 0; cyc = 0;
      while (n < 6 && cyc < 600) begin
        @(posedge clk); @(negedge clk);
        cyc++;
        // Once RUN is entered the captured taps/seed must no longer matter.
        if (cyc >= 2) begin
          taps      = rand_taps();
          seed      = SZ'($urandom);
          ena       = ($urandom_range(0, 99) < 85);
          out_ready = ($urandom_range(0, 99) < 70);
        end
        if (dout_valid && out_ready && ena) begin
          vectors++; if (dout !== exp_q[n]) begin
            errors++; $display("FAIL random_it%0d_byte%0d: got %h expected %h", it, n, dout, exp_q[n]);
          end
          n++;
        end
      end
      vectors++; if (n != 6) begin errors++; $display("FAIL random_it%0d_timeout: got %0d bytes expected 6", it, n); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seed_zero();
    test_stall();
    test_mask_rule();
    test_ena_gap();
    test_async_reset();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
